plab2_proc_imul_arbiter: RTL and testbench

- Shares one variable-latency integer multiplier (plab1_imul_IntMulVarLat) between the D-stage multiply ports of p_num_cores pipelined processor cores.
- Performs round-robin arbitration of requests and allows one operation outstanding at a time.
- Remembers which core owns the in-flight operation and routes the multiplier response back to that core only.
- Sits between each core datapath (mul_req_*_D / mul_resp_*_X) and the single multiplier instance in the multicore tile.

---
 rtl/plab2_proc_imul_arbiter_pkg.sv | 24 ++
 rtl/plab2_proc_imul_arbiter_rr_arb.sv | 30 +++
 rtl/plab2_proc_imul_arbiter.sv | 112 +++++++++++
 tb/tb_plab2_proc_imul_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab2_proc_imul_arbiter_pkg.sv
// Shared types for the multicore integer-multiplier arbiter: FSM encoding,
// multiplier request message layout and pointer-width helper.
package plab2_proc_imul_arbiter_pkg;

  localparam int unsigned imul_req_nbits = 67;

  // Multiplier request: {func, a, b}; func 0 selects multiply.
  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } imul_req_msg_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Pointer/owner width; a single core still needs one storage bit.
  function automatic int unsigned ptr_nbits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab2_proc_imul_arbiter_rr_arb.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module plab2_proc_imul_arbiter_rr_arb #(
  parameter int unsigned p_num_cores = 4,
  parameter int unsigned p_ptr_nbits = 2
) (
  input  logic [p_num_cores-1:0] req,
  input  logic [p_ptr_nbits-1:0] ptr,
  output logic [p_num_cores-1:0] grant,
  output logic [p_ptr_nbits-1:0] grant_idx
);

  logic                   found;
  logic [p_ptr_nbits-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < p_num_cores; i++) begin
      sel = p_ptr_nbits'((32'(ptr) + i) % p_num_cores);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plab2_proc_imul_arbiter.sv
// Shares one variable-latency multiplier among several cores: round-robin
// issue, one operation in flight, response routed back to the issuing core.
module plab2_proc_imul_arbiter
  import plab2_proc_imul_arbiter_pkg::*;
#(
  parameter int unsigned p_num_cores = 4,
  parameter int unsigned p_req_nbits = imul_req_nbits
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_num_cores-1:0]             req_val,
  output logic [p_num_cores-1:0]             req_rdy,
  input  logic [p_num_cores*p_req_nbits-1:0] req_msg,
  output logic [p_num_cores-1:0]             resp_val,
  input  logic [p_num_cores-1:0]             resp_rdy,
  output logic [31:0]                        resp_msg,
  output logic                               mul_in_val,
  input  logic                               mul_in_rdy,
  output logic [p_req_nbits-1:0]             mul_in_msg,
  input  logic                               mul_out_val,
  output logic                               mul_out_rdy,
  input  logic [31:0]                        mul_out_msg
);

  localparam int unsigned ptr_w = ptr_nbits(p_num_cores);
  localparam logic [ptr_w-1:0] last_idx = ptr_w'(p_num_cores - 1);

  arb_state_e             state, state_next;
  logic [ptr_w-1:0]       ptr, ptr_next;
  logic [ptr_w-1:0]       owner, owner_next;
  logic [p_num_cores-1:0] grant;
  logic [ptr_w-1:0]       grant_idx;
  logic                   issue_xfer;
  logic                   resp_xfer;

  plab2_proc_imul_arbiter_rr_arb #(
    .p_num_cores (p_num_cores),
    .p_ptr_nbits (ptr_w)
  ) u_rr_arb (
    .req       (req_val),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign issue_xfer = (|req_val) & mul_in_rdy;
  assign resp_xfer  = mul_out_val & resp_rdy[owner];

  // State, pointer and owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

  // Next-state: advance the pointer past the granted core only on a real issue
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (issue_xfer) begin
          owner_next = grant_idx;
          ptr_next   = (grant_idx == last_idx) ? '0 : ptr_w'(grant_idx + 1'b1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (resp_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: request steering in IDLE, response routing in BUSY
  always_comb begin
    req_rdy     = '0;
    resp_val    = '0;
    resp_msg    = mul_out_msg;
    mul_in_val  = 1'b0;
    mul_in_msg  = '0;
    mul_out_rdy = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          mul_in_val = |req_val;
          req_rdy    = grant & {p_num_cores{mul_in_rdy}};
          for (int unsigned i = 0; i < p_num_cores; i++) begin
            if (grant[i]) begin
              mul_in_msg = req_msg[i*p_req_nbits +: p_req_nbits];
            end
          end
        end
        BUSY: begin
          resp_val[owner] = mul_out_val;
          mul_out_rdy     = resp_rdy[owner];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plab2_proc_imul_arbiter.sv
// Directed bench for the shared-multiplier arbiter with a fixed-latency
// multiplier model on the far side.
module tb_plab2_proc_imul_arbiter;
  import plab2_proc_imul_arbiter_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = imul_req_nbits;
  localparam int unsigned LAT = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_val, req_rdy;
  logic [N*W-1:0] req_msg;
  logic [N-1:0]   resp_val, resp_rdy;
  logic [31:0]    resp_msg;
  logic           mul_in_val, mul_in_rdy;
  logic [W-1:0]   mul_in_msg;
  logic           mul_out_val, mul_out_rdy;
  logic [31:0]    mul_out_msg;

  logic           mul_rdy_en;
  logic           mdl_busy;
  int unsigned    mdl_cnt;
  imul_req_msg_t  in_m;

  int num_checks = 0;
  int num_fails  = 0;
  int grant_q[$];
  int resp_core_q[$];
  logic [31:0] resp_msg_q[$];
  logic [31:0] prod [4] = '{32'd20, 32'd33, 32'd48, 32'd65};

  always #5 clk = ~clk;

  plab2_proc_imul_arbiter #(.p_num_cores(N), .p_req_nbits(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_msg     (req_msg),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_msg    (resp_msg),
    .mul_in_val  (mul_in_val),
    .mul_in_rdy  (mul_in_rdy),
    .mul_in_msg  (mul_in_msg),
    .mul_out_val (mul_out_val),
    .mul_out_rdy (mul_out_rdy),
    .mul_out_msg (mul_out_msg)
  );

  // Fixed-latency multiplier: response valid LAT cycles after the issue cycle
  assign in_m       = mul_in_msg;
  assign mul_in_rdy = mul_rdy_en & ~mdl_busy;

  always @(posedge clk) begin
    if (reset) begin
      mdl_busy    <= 1'b0;
      mdl_cnt     <= 0;
      mul_out_val <= 1'b0;
      mul_out_msg <= '0;
    end else if (mul_in_val && mul_in_rdy) begin
      mdl_busy    <= 1'b1;
      mdl_cnt     <= LAT - 1;
      mul_out_msg <= 32'(in_m.a * in_m.b);
    end else if (mdl_busy && !mul_out_val) begin
      if (mdl_cnt <= 1) mul_out_val <= 1'b1;
      else mdl_cnt <= mdl_cnt - 1;
    end else if (mul_out_val && mul_out_rdy) begin
      mul_out_val <= 1'b0;
      mdl_busy    <= 1'b0;
    end
  end

  // Record issued grants and delivered responses
  always @(posedge clk) begin
    if (!reset) begin
      if (mul_in_val && mul_in_rdy)
        for (int i = 0; i < N; i++) if (req_rdy[i]) grant_q.push_back(i);
      for (int i = 0; i < N; i++) begin
        if (resp_val[i] && resp_rdy[i]) begin
          resp_core_q.push_back(i);
          resp_msg_q.push_back(resp_msg);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic imul_req_msg_t mk(input logic [31:0] a, input logic [31:0] b);
    imul_req_msg_t m;
    m.func = 3'd0;
    m.a    = a;
    m.b    = b;
    return m;
  endfunction

  task automatic set_op(input int core, input logic [31:0] a, input logic [31:0] b);
    req_msg[core*W +: W] = mk(a, b);
  endtask

  task automatic clear_logs();
    grant_q.delete();
    resp_core_q.delete();
    resp_msg_q.delete();
  endtask

  // Hold requests until n grants are logged, then drop them and let the op finish
  task automatic wait_grants(input int n);
    int k = 0;
    while (grant_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    req_val = '0;
    check_eq("grant_count", 80'(grant_q.size()), 80'(n));
    k = 0;
    while (mdl_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_done", 80'(mdl_busy), 80'(0));
  endtask

  initial begin
    reset      = 1'b1;
    req_val    = '0;
    req_msg    = '0;
    resp_rdy   = '1;
    mul_rdy_en = 1'b1;

    // Outputs held quiet during reset even with requests pending
    @(negedge clk);
    @(negedge clk);
    req_val = '1;
    #1;
    check_eq("rst_req_rdy", 80'(req_rdy), 80'(0));
    check_eq("rst_mul_in_val", 80'(mul_in_val), 80'(0));
    check_eq("rst_resp_val", 80'(resp_val), 80'(0));
    check_eq("rst_mul_out_rdy", 80'(mul_out_rdy), 80'(0));
    @(negedge clk);
    reset   = 1'b0;
    req_val = '0;

    // Single request from core 2: 3*7
    set_op(2, 32'd3, 32'd7);
    @(negedge clk);
    req_val = 4'b0100;
    #1;
    check_eq("single_req_rdy", 80'(req_rdy), 80'(4'b0100));
    check_eq("single_in_msg", 80'(mul_in_msg), 80'(mk(32'd3, 32'd7)));
    @(negedge clk);
    req_val = '0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("single_wait", 80'(resp_val), 80'(0));
      @(negedge clk);
    end
    #1;
    check_eq("single_resp_val", 80'(resp_val), 80'(4'b0100));
    check_eq("single_resp_msg", 80'(resp_msg), 80'(21));
    @(negedge clk);
    #1;
    check_eq("single_done", 80'(resp_val), 80'(0));
    check_eq("single_resp_n", 80'(resp_core_q.size()), 80'(1));

    // Round robin: all cores request continuously from ptr=0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 2), 32'(i + 10));
    req_val = '1;
    wait_grants(8);
    check_eq("rr_resp_n", 80'(resp_core_q.size()), 80'(8));
    for (int i = 0; i < 8; i++) begin
      check_eq("rr_grant", 80'(grant_q[i]), 80'(i % 4));
      if (i < resp_core_q.size()) begin
        check_eq("rr_resp_core", 80'(resp_core_q[i]), 80'(i % 4));
        check_eq("rr_resp_msg", 80'(resp_msg_q[i]), 80'(prod[i % 4]));
      end
    end

    // Pointer skip: serve core 0, then cores 0 and 3 compete -> 3 then 0
    clear_logs();
    @(negedge clk);
    req_val = 4'b0001;
    wait_grants(1);
    req_val = 4'b1001;
    wait_grants(3);
    check_eq("skip_g0", 80'(grant_q[0]), 80'(0));
    check_eq("skip_g1", 80'(grant_q[1]), 80'(3));
    check_eq("skip_g2", 80'(grant_q[2]), 80'(0));

    // Response backpressure from owner core 1 while core 2 waits
    clear_logs();
    set_op(1, 32'd6, 32'd7);
    set_op(2, 32'd9, 32'd9);
    @(negedge clk);
    req_val = 4'b0010;
    #1;
    check_eq("bp_issue", 80'(req_rdy), 80'(4'b0010));
    @(negedge clk);
    req_val  = 4'b0100;
    resp_rdy = 4'b1101;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check_eq("bp_req_rdy", 80'(req_rdy), 80'(0));
      check_eq("bp_mul_out_rdy", 80'(mul_out_rdy), 80'(0));
      check_eq("bp_resp_val", 80'(resp_val), (k >= 4) ? 80'(4'b0010) : 80'(0));
      @(negedge clk);
    end
    resp_rdy = '1;
    #1;
    check_eq("bp_accept_val", 80'(resp_val), 80'(4'b0010));
    check_eq("bp_accept_rdy", 80'(mul_out_rdy), 80'(1));
    check_eq("bp_accept_msg", 80'(resp_msg), 80'(42));
    check_eq("bp_accept_req_rdy", 80'(req_rdy), 80'(0));
    @(negedge clk);
    #1;
    check_eq("bp_next_grant", 80'(req_rdy), 80'(4'b0100));
    wait_grants(2);
    check_eq("bp_resp_n", 80'(resp_core_q.size()), 80'(2));
    if (resp_core_q.size() == 2) begin
      check_eq("bp_resp_core1", 80'(resp_core_q[1]), 80'(2));
      check_eq("bp_resp_msg1", 80'(resp_msg_q[1]), 80'(81));
    end

    // Multiplier not ready: no grant consumed until mul_in_rdy rises
    clear_logs();
    mul_rdy_en = 1'b0;
    set_op(0, 32'd5, 32'd5);
    set_op(1, 32'd2, 32'd8);
    @(negedge clk);
    req_val = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check_eq("nr_req_rdy", 80'(req_rdy), 80'(0));
      check_eq("nr_mul_in_val", 80'(mul_in_val), 80'(1));
      @(negedge clk);
    end
    mul_rdy_en = 1'b1;
    #1;
    check_eq("nr_grant", 80'(req_rdy), 80'(4'b0001));
    check_eq("nr_in_msg", 80'(mul_in_msg), 80'(mk(32'd5, 32'd5)));
    wait_grants(1);
    check_eq("nr_resp_msg", 80'(resp_msg_q.size() == 1 ? resp_msg_q[0] : 32'hx), 80'(25));

    // Reset while core 3 owns the multiplier
    clear_logs();
    set_op(3, 32'd4, 32'd4);
    @(negedge clk);
    req_val = 4'b1000;
    #1;
    check_eq("rm_issue", 80'(req_rdy), 80'(4'b1000));
    @(negedge clk);
    req_val = '0;
    reset   = 1'b1;
    #1;
    check_eq("rm_in_reset", 80'(resp_val), 80'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rm_resp_val", 80'(resp_val), 80'(0));
    check_eq("rm_mul_out_rdy", 80'(mul_out_rdy), 80'(0));
    check_eq("rm_idle", 80'(mul_in_val), 80'(0));
    set_op(0, 32'd12, 32'd12);
    @(negedge clk);
    req_val = 4'b1001;
    #1;
    check_eq("rm_ptr_zero", 80'(req_rdy), 80'(4'b0001));
    wait_grants(2);
    check_eq("rm_resp_n", 80'(resp_core_q.size()), 80'(1));
    if (resp_core_q.size() == 1) begin
      check_eq("rm_resp_core", 80'(resp_core_q[0]), 80'(0));
      check_eq("rm_resp_msg", 80'(resp_msg_q[0]), 80'(144));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
